obu_bit_reader: RTL and testbench

Downstream consumer of the OBU field aligner. Takes the aligner's 32-bit, MSB-first word stream and buffers it in a 64-bit shift window. It serves parser requests for fixed-width fields f(n), leb128 values and byte_alignment(), and pops a new aligned word whenever space allows. It sits between the aligner and the OBU header/sequence-header parse FSMs, which issue one request at a time.

---
 rtl/obu_bit_reader.sv | 256 +++++++++++++++++++++++++
 tb/tb_obu_bit_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obu_bit_reader.sv
// ---------------------------------------------------------------------------
// obu_bit_reader
//
// Bit-level reader placed between the OBU field aligner and the OBU header /
// sequence-header parse FSMs. Aligned 32-bit words (MSB first) are buffered
// in a 64-bit left-justified shift window. The parser issues one request at
// a time: a fixed-width field f(n), a leb128 value, or byte_alignment().
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous clear of window, counters and FSM (new OBU)
//   word_in        aligned word from the aligner, bit 31 first in stream
//   word_valid     word_in holds a word
//   word_pop       word consumed this cycle (aligner pop)
//   req_valid      request present
//   req_ready      reader accepts a request (FSM idle)
//   req_mode       00 f(n), 01 leb128, 10 byte_align, 11 reserved
//   req_len        n for f(n), legal 0..32
//   rsp_valid      result present, held until rsp_ready
//   rsp_ready      consumer accepts the result
//   rsp_data       field value, right-justified, zero-extended
//   rsp_err        illegal request or leb128 overflow
//   bits_consumed  bits retired since reset/flush, wraps modulo 2^32
// ---------------------------------------------------------------------------
module obu_bit_reader #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_pop,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_mode,
   input  logic [5:0]            req_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [31:0]           bits_consumed
);

   localparam logic [1:0] MODE_FIX = 2'b00;
   localparam logic [1:0] MODE_LEB = 2'b01;
   localparam logic [1:0] MODE_ALN = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIX,
      S_LEB,
      S_ALN,
      S_RSP
   } state_t;

   state_t        state_reg, state_next;

   // Window: valid bits left-justified at win_reg[63]; bits below level are 0
   // so that a refill can simply be OR-ed in.
   logic [63:0]   win_reg, win_next;
   logic [6:0]    level_reg, level_next;
   logic [31:0]   bc_reg, bc_next;

   logic [5:0]    len_reg, len_next;
   logic [55:0]   leb_acc_reg, leb_acc_next;
   logic [2:0]    leb_cnt_reg, leb_cnt_next;
   logic [31:0]   data_reg, data_next;
   logic          err_reg, err_next;

   // Per-cycle consume amount (0..32) decided by the FSM.
   logic [5:0]    consume;

   logic [31:0]   fix_data;
   logic [7:0]    leb_byte;
   logic [5:0]    leb_shift;
   logic [2:0]    aln_bits;
   logic [63:0]   win_shifted;
   logic [6:0]    level_avail;
   logic [63:0]   win_fill;

   // ------------------------------------------------------------------
   // Refill. level <= 32 leaves room for a full word even if nothing is
   // consumed this cycle. Held low during reset and flush so the aligner
   // never loses a word into registers that are being cleared.
   // ------------------------------------------------------------------
   assign word_pop = rst_n && !flush && word_valid && (level_reg <= 7'd32);

   // ------------------------------------------------------------------
   // Field extraction helpers
   // ------------------------------------------------------------------
   // win[63 -: n] right-justified; a shift by 32 (n = 0) yields 0.
   assign fix_data  = win_reg[63:32] >> (6'd32 - len_reg);

   assign leb_byte  = win_reg[63:56];
   // 7 * leb_cnt as 8*cnt - cnt, max 49.
   assign leb_shift = {leb_cnt_reg, 3'b000} - {3'b000, leb_cnt_reg};

   // (8 - bits_consumed[2:0]) & 7 is the 3-bit two's complement.
   assign aln_bits  = 3'd0 - bc_reg[2:0];

   // ------------------------------------------------------------------
   // Next-state / response logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      leb_acc_next = leb_acc_reg;
      leb_cnt_next = leb_cnt_reg;
      data_next    = data_reg;
      err_next     = err_reg;
      consume      = 6'd0;

      case (state_reg)
         S_IDLE: begin
            if (req_valid) begin
               len_next     = req_len;
               leb_acc_next = 56'd0;
               leb_cnt_next = 3'd0;
               data_next    = 32'd0;
               err_next     = 1'b0;
               if ((req_mode == 2'b11) || (req_len > 6'd32)) begin
                  // Rejected without touching the window.
                  err_next   = 1'b1;
                  state_next = S_RSP;
               end else if (req_mode == MODE_FIX) begin
                  state_next = S_FIX;
               end else if (req_mode == MODE_LEB) begin
                  state_next = S_LEB;
               end else if (req_mode == MODE_ALN) begin
                  state_next = S_ALN;
               end
            end
         end

         S_FIX: begin
            if (level_reg >= {1'b0, len_reg}) begin
               consume    = len_reg;
               data_next  = fix_data;
               state_next = S_RSP;
            end
         end

         S_LEB: begin
            if (level_reg >= 7'd8) begin
               consume      = 6'd8;
               leb_acc_next = leb_acc_reg
                            | ({49'd0, leb_byte[6:0]} << leb_shift);
               leb_cnt_next = leb_cnt_reg + 3'd1;
               // Stop on a terminating byte or after the 8th byte.
               if (!leb_byte[7] || (leb_cnt_reg == 3'd7)) begin
                  state_next = S_RSP;
                  data_next  = leb_acc_next[31:0];
                  // A continuation bit can only survive to here on the
                  // 8th byte, so leb_byte[7] alone flags that case.
                  err_next   = (|leb_acc_next[55:32]) || leb_byte[7];
               end
            end
         end

         S_ALN: begin
            if (level_reg >= {4'd0, aln_bits}) begin
               consume    = {3'd0, aln_bits};
               data_next  = 32'd0;
               state_next = S_RSP;
            end
         end

         S_RSP: begin
            if (rsp_ready) begin
               data_next  = 32'd0;
               err_next   = 1'b0;
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Window datapath: consume first, then append the popped word directly
   // behind the remaining valid bits.
   // ------------------------------------------------------------------
   always_comb begin
      win_shifted = win_reg << consume;
      level_avail = level_reg - {1'b0, consume};
      win_fill    = 64'd0;
      if (word_pop) begin
         win_fill = {word_in, 32'd0} >> level_avail;
      end
      win_next    = win_shifted | win_fill;
      level_next  = level_avail + (word_pop ? 7'd32 : 7'd0);
      bc_next     = bc_reg + {26'd0, consume};
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else if (flush) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_reg     <= 64'd0;
         level_reg   <= 7'd0;
         bc_reg      <= 32'd0;
         len_reg     <= 6'd0;
         leb_acc_reg <= 56'd0;
         leb_cnt_reg <= 3'd0;
         data_reg    <= 32'd0;
         err_reg     <= 1'b0;
      end else if (flush) begin
         win_reg     <= 64'd0;
         level_reg   <= 7'd0;
         bc_reg      <= 32'd0;
         len_reg     <= 6'd0;
         leb_acc_reg <= 56'd0;
         leb_cnt_reg <= 3'd0;
         data_reg    <= 32'd0;
         err_reg     <= 1'b0;
      end else begin
         win_reg     <= win_next;
         level_reg   <= level_next;
         bc_reg      <= bc_next;
         len_reg     <= len_next;
         leb_acc_reg <= leb_acc_next;
         leb_cnt_reg <= leb_cnt_next;
         data_reg    <= data_next;
         err_reg     <= err_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign req_ready     = (state_reg == S_IDLE);
   assign rsp_valid     = (state_reg == S_RSP);
   assign rsp_data      = data_reg;
   assign rsp_err       = err_reg;
   assign bits_consumed = bc_reg;

endmodule

// File: tb/tb_obu_bit_reader.sv
module tb_obu_bit_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_pop;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_mode = 2'b00;
    logic [5:0]  req_len = 6'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] bits_consumed;

    always #5 clk = ~clk;

    obu_bit_reader #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_pop      (word_pop),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_len       (req_len),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .bits_consumed (bits_consumed)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] bc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    string       sb_tag[$];
    logic [31:0] wq[$];
    bit          feed_en = 1'b0;
    bit          accepted = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t  e;
        string t;
        word_valid = feed_en && (wq.size() > 0);
        word_in    = (wq.size() > 0) ? wq[0] : 32'h0;
        #1;
        accepted = req_valid && req_ready;
        if (accepted) acc_cyc = cyc;
        if (word_pop && (wq.size() > 0)) void'(wq.pop_front());
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                t = sb_tag.pop_front();
                $display("rsp %-10s data=0x%08h err=%0d bits_consumed=%0d lat=%0d",
                         t, rsp_data, rsp_err, bits_consumed, cyc - acc_cyc);
                chk({t, "_data"}, rsp_data, e.data);
                chk({t, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                chk({t, "_bits"}, bits_consumed, e.bc);
                if (e.lat >= 0) chk({t, "_lat"}, cyc - acc_cyc, e.lat);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input logic [1:0] mode, input logic [5:0] len,
                         input bit push, input logic [31:0] d, input logic e,
                         input logic [31:0] bc, input int lat, input string tag);
        exp_t x;
        int   n;
        if (push) begin
            x.data = d; x.err = e; x.bc = bc; x.lat = lat;
            sb.push_back(x);
            sb_tag.push_back(tag);
        end
        req_mode  = mode;
        req_len   = len;
        req_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        req_valid = 1'b0;
        chk({tag, "_accept"}, {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_timeout", sb.size(), 32'd0);
        sb.delete();
        sb_tag.delete();
    endtask

    task automatic flush_dut();
        wq.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_word_pop"}, {31'd0, word_pop}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_bits"}, bits_consumed, 32'd0);
    endtask

    initial begin
        int seen;
        int n;

        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n   = 1'b1;
        feed_en = 1'b1;

        wq.push_back(32'hA5C30F81);
        wq.push_back(32'h12345678);
        idle(3);
        issue(2'b00, 6'd4,  1, 32'hA,     1'b0, 32'd4,  2, "f4");
        wait_rsp(20);
        issue(2'b00, 6'd12, 1, 32'h5C3,   1'b0, 32'd16, 2, "f12");
        wait_rsp(20);
        issue(2'b00, 6'd20, 1, 32'h0F811, 1'b0, 32'd36, 2, "f20");
        wait_rsp(20);

        flush_dut();
        chk("flush_bits", bits_consumed, 32'd0);
        wq.push_back(32'hE58E2600);
        idle(2);
        issue(2'b01, 6'd0, 1, 32'd624485, 1'b0, 32'd24, 4, "leb");
        wait_rsp(20);

        flush_dut();
        wq.push_back(32'hFFFFFFFF);
        wq.push_back(32'h0F000000);
        idle(3);
        issue(2'b01, 6'd0, 1, 32'hFFFFFFFF, 1'b0, 32'd40, 6, "leb_max");
        wait_rsp(20);
        flush_dut();
        wq.push_back(32'hFFFFFFFF);
        wq.push_back(32'h1F000000);
        idle(3);
        issue(2'b01, 6'd0, 1, 32'hFFFFFFFF, 1'b1, 32'd40, 6, "leb_ovf");
        wait_rsp(20);

        flush_dut();
        wq.push_back(32'hA5C30F81);
        wq.push_back(32'h12345678);
        idle(3);
        issue(2'b00, 6'd3, 1, 32'h5, 1'b0, 32'd3, 2, "f3");
        wait_rsp(20);
        issue(2'b10, 6'd0, 1, 32'h0, 1'b0, 32'd8, 2, "align");
        wait_rsp(20);
        rsp_ready = 1'b0;
        issue(2'b00, 6'd8, 1, 32'hC3, 1'b0, 32'd16, -1, "f8_hold");
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", rsp_data, 32'hC3);
            tick();
        end
        rsp_ready = 1'b1;
        wait_rsp(20);

        flush_dut();
        feed_en = 1'b0;
        wq.push_back(32'hDEADBEEF);
        issue(2'b00, 6'd32, 1, 32'hDEADBEEF, 1'b0, 32'd32, -1, "f32_starve");
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        chk("starve_no_rsp", seen, 32'd0);
        feed_en = 1'b1;
        wait_rsp(20);

        flush_dut();
        wq.push_back(32'hFFFFFFFF);
        idle(2);
        issue(2'b01, 6'd0, 0, 32'd0, 1'b0, 32'd0, -1, "leb_flushed");
        idle(6);
        flush_dut();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        chk("flush_no_rsp", seen, 32'd0);
        chk("flush_leb_bits", bits_consumed, 32'd0);
        chk("flush_ready", {31'd0, req_ready}, 32'd1);

        issue(2'b11, 6'd8,  1, 32'd0, 1'b1, 32'd0, 1, "mode11");
        wait_rsp(20);
        issue(2'b00, 6'd40, 1, 32'd0, 1'b1, 32'd0, 1, "len40");
        wait_rsp(20);

        feed_en = 1'b0;
        wq.push_back(32'h13572468);
        issue(2'b00, 6'd32, 0, 32'd0, 1'b0, 32'd0, -1, "f32_reset");
        idle(3);
        rst_n = 1'b0;
        wq.delete();
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        feed_en = 1'b1;
        wq.push_back(32'hA5C30F81);
        idle(2);
        issue(2'b00, 6'd8, 1, 32'hA5, 1'b0, 32'd8, 2, "f8_after_rst");
        wait_rsp(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
